// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: FSM encoding,
// legal byte-strobe patterns and the wait-state counter width.
package dmem_pkg;

    localparam int unsigned CntWidth = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

    localparam logic [3:0] StrbByte0 = 4'b0001;
    localparam logic [3:0] StrbByte1 = 4'b0010;
    localparam logic [3:0] StrbByte2 = 4'b0100;
    localparam logic [3:0] StrbByte3 = 4'b1000;
    localparam logic [3:0] StrbHalf0 = 4'b0011;
    localparam logic [3:0] StrbHalf1 = 4'b1100;
    localparam logic [3:0] StrbWord  = 4'b1111;

    function automatic logic strobe_legal(input logic [3:0] wen);
        return (wen == StrbByte0) || (wen == StrbByte1) || (wen == StrbByte2) ||
               (wen == StrbByte3) || (wen == StrbHalf0) || (wen == StrbHalf1) ||
               (wen == StrbWord);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word array with per-byte-lane write enables; on a commit edge it writes the
// enabled lanes and registers the post-write (merged) word onto rdata.
module dmem_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned IdxWidth = $clog2(DEPTH_WORDS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                commit,
    input  logic                clear,
    input  logic [3:0]          lane_we,
    input  logic [IdxWidth-1:0] idx,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] merged;

    always_comb begin
        merged = mem[idx];
        for (int i = 0; i < 4; i++) begin
            if (lane_we[i]) merged[8*i +: 8] = wdata[8*i +: 8];
        end
    end

    // Contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (commit) begin
            rdata <= clear ? '0 : merged;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-side memory responder for the pipelined core: one request at a time,
// WAIT_CYCLES wait states, then a one-cycle completion pulse with read data.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic [3:0]  wen_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic [31:0] rdata_o,
    output logic        data_ok_o,
    output logic        err_o
);

    localparam int unsigned IdxWidth = $clog2(DEPTH_WORDS);
    localparam logic [CntWidth-1:0] CntLoad =
        (WAIT_CYCLES != 0) ? CntWidth'(WAIT_CYCLES - 1) : '0;

    state_e              state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [31:0]         addr_q, wdata_q;
    logic [3:0]          wen_q;
    logic                err_q;
    logic                commit;

    logic [31:0]         cur_addr, cur_wdata;
    logic [3:0]          cur_wen;
    logic                out_of_range, bad_strobe, acc_err;
    logic [3:0]          lane_we;
    logic                unused_addr_lsb;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (commit) err_q <= acc_err;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == StIdle && req_i) begin
            addr_q  <= addr_i;
            wen_q   <= wen_i;
            wdata_q <= wdata_i;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_i) begin
                    if (WAIT_CYCLES != 0) begin
                        state_d = StWait;
                        cnt_d   = CntLoad;
                    end else begin
                        state_d = StResp;
                        commit  = 1'b1;
                    end
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StResp;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntWidth'(1);
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // A zero-wait access commits in its acceptance cycle, so use live inputs there.
    always_comb begin
        cur_addr     = (state_q == StIdle) ? addr_i : addr_q;
        cur_wen      = (state_q == StIdle) ? wen_i : wen_q;
        cur_wdata    = (state_q == StIdle) ? wdata_i : wdata_q;
        out_of_range = cur_addr[31:2] >= 30'(DEPTH_WORDS);
        bad_strobe   = (cur_wen != 4'b0000) && !strobe_legal(cur_wen);
        acc_err      = out_of_range || bad_strobe;
        lane_we      = acc_err ? 4'b0000 : cur_wen;
    end

    assign unused_addr_lsb = ^cur_addr[1:0];

    always_comb begin
        busy_o    = 1'b0;
        data_ok_o = 1'b0;
        err_o     = 1'b0;
        unique case (state_q)
            StIdle: busy_o = req_i;
            StWait: busy_o = 1'b1;
            StResp: begin
                data_ok_o = 1'b1;
                err_o     = err_q;
            end
            default: busy_o = 1'b0;
        endcase
    end

    // Reset on the commit edge discards the access.
    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk    (clk),
        .rst    (rst),
        .commit (commit && !rst),
        .clear  (out_of_range),
        .lane_we(lane_we),
        .idx    (cur_addr[IdxWidth+1:2]),
        .wdata  (cur_wdata),
        .rdata  (rdata_o)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a WAIT_CYCLES=2 instance for the main
// scenarios and a WAIT_CYCLES=0 instance for back-to-back timing.
module tb_dmem_responder;

    localparam int unsigned Depth = 1024;
    localparam int unsigned Wait2 = 2;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req2, busy2, ok2, err2;
    logic [3:0]  wen2;
    logic [31:0] addr2, wdata2, rdata2;
    logic        req0, busy0, ok0, err0;
    logic [3:0]  wen0;
    logic [31:0] addr0, wdata0, rdata0;

    exp_t        q2[$];
    exp_t        q0[$];
    logic [31:0] mem2[int];
    logic [31:0] mem0[int];
    int          checks = 0;
    int          errors = 0;

    dmem_responder #(.DEPTH_WORDS(Depth), .WAIT_CYCLES(Wait2)) dut (
        .clk(clk), .rst(rst), .req_i(req2), .wen_i(wen2), .addr_i(addr2), .wdata_i(wdata2),
        .busy_o(busy2), .rdata_o(rdata2), .data_ok_o(ok2), .err_o(err2)
    );

    dmem_responder #(.DEPTH_WORDS(Depth), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req_i(req0), .wen_i(wen0), .addr_i(addr0), .wdata_i(wdata0),
        .busy_o(busy0), .rdata_o(rdata0), .data_ok_o(ok0), .err_o(err0)
    );

    // Reference model: computes the expected response and updates the model memory.
    task automatic model(input bit zero_wait, input logic [3:0] wen, input logic [31:0] addr,
                         input logic [31:0] wdata);
        exp_t        e;
        int          idx;
        logic [31:0] old;
        bit          legal;
        idx   = int'(addr[11:2]);
        legal = wen inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                            4'b0011, 4'b1100, 4'b1111};
        if (zero_wait) old = mem0.exists(idx) ? mem0[idx] : 32'h0;
        else           old = mem2.exists(idx) ? mem2[idx] : 32'h0;
        if (addr >= 32'h0000_1000) begin
            e = {32'h0, 1'b1};
        end else if (!legal) begin
            e = {old, 1'b1};
        end else begin
            e.rdata = old;
            for (int i = 0; i < 4; i++) begin
                if (wen[i]) e.rdata[8*i +: 8] = wdata[8*i +: 8];
            end
            e.err = 1'b0;
            if (zero_wait) mem0[idx] = e.rdata;
            else           mem2[idx] = e.rdata;
        end
        if (zero_wait) q0.push_back(e);
        else           q2.push_back(e);
    endtask

    // One complete access on the WAIT_CYCLES=2 instance; entered and left just after a posedge.
    task automatic access2(input logic [3:0] wen, input logic [31:0] addr,
                           input logic [31:0] wdata);
        int   cycles;
        bit   seen;
        exp_t e;
        model(1'b0, wen, addr, wdata);
        req2 = 1'b1; wen2 = wen; addr2 = addr; wdata2 = wdata;
        cycles = 0;
        seen = 1'b0;
        while (!seen && cycles < 20) begin
            @(negedge clk);
            if (ok2 === 1'b1) begin
                seen = 1'b1;
            end else begin
                checks++;
                if (busy2 !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_in_flight addr=%h cycle=%0d busy_o=%b required 1",
                             addr, cycles, busy2);
                end
                cycles++;
                @(posedge clk); #1;
            end
        end
        e = q2.pop_front();
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL data_ok_timeout addr=%h no data_ok_o within %0d cycles", addr, cycles);
        end else begin
            if (cycles !== Wait2 + 1) begin
                errors++;
                $display("FAIL latency addr=%h got %0d cycles required %0d",
                         addr, cycles, Wait2 + 1);
            end
            checks++;
            if (busy2 !== 1'b0) begin
                errors++;
                $display("FAIL busy_in_resp addr=%h busy_o=%b required 0", addr, busy2);
            end
            checks++;
            if (rdata2 !== e.rdata || err2 !== e.err) begin
                errors++;
                $display("FAIL response addr=%h wen=%b rdata=%h err=%b required rdata=%h err=%b",
                         addr, wen, rdata2, err2, e.rdata, e.err);
            end
        end
        @(posedge clk); #1;
        req2 = 1'b0; wen2 = 4'($urandom); addr2 = $urandom; wdata2 = $urandom;
        @(negedge clk);
        checks++;
        if (ok2 !== 1'b0 || err2 !== 1'b0 || rdata2 !== e.rdata) begin
            errors++;
            $display("FAIL after_resp addr=%h data_ok=%b err=%b rdata=%h required 0 0 %h",
                     addr, ok2, err2, rdata2, e.rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req2 = 1'b0; wen2 = '0; addr2 = '0; wdata2 = '0;
        req0 = 1'b0; wen0 = '0; addr0 = '0; wdata0 = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks += 2;
        if (busy2 !== 1'b0 || ok2 !== 1'b0 || err2 !== 1'b0 || rdata2 !== 32'h0) begin
            errors++;
            $display("FAIL reset_w2 busy=%b ok=%b err=%b rdata=%h required 0 0 0 0",
                     busy2, ok2, err2, rdata2);
        end
        if (busy0 !== 1'b0 || ok0 !== 1'b0 || err0 !== 1'b0 || rdata0 !== 32'h0) begin
            errors++;
            $display("FAIL reset_w0 busy=%b ok=%b err=%b rdata=%h required 0 0 0 0",
                     busy0, ok0, err0, rdata0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_full_write();
        access2(4'b1111, 32'h10, 32'hDEAD_BEEF);
        access2(4'b0000, 32'h10, 32'h0);
    endtask

    task automatic test_byte_write();
        access2(4'b0100, 32'h12, 32'h00AA_0000);
        access2(4'b0000, 32'h10, 32'h0);
        access2(4'b0000, 32'h13, 32'h0);
    endtask

    task automatic test_out_of_range();
        access2(4'b1111, 32'h0, 32'h0BAD_F00D);
        access2(4'b0000, 32'h1000, 32'h0);
        access2(4'b1111, 32'h1000, 32'hFFFF_FFFF);
        access2(4'b0000, 32'h0, 32'h0);
    endtask

    task automatic test_illegal_strobe();
        access2(4'b0101, 32'h10, 32'hFFFF_FFFF);
        access2(4'b0000, 32'h10, 32'h0);
        access2(4'b1001, 32'h10, 32'h1111_1111);
    endtask

    task automatic test_reset_abort();
        access2(4'b1111, 32'h20, 32'h1111_2222);
        req2 = 1'b1; wen2 = 4'b1111; addr2 = 32'h20; wdata2 = 32'h1234_5678;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy2 !== 1'b1) begin
            errors++;
            $display("FAIL abort_in_wait busy_o=%b required 1", busy2);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        req2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (ok2 !== 1'b0 || busy2 !== 1'b0 || rdata2 !== 32'h0) begin
                errors++;
                $display("FAIL abort_idle cycle=%0d ok=%b busy=%b rdata=%h required 0 0 0",
                         i, ok2, busy2, rdata2);
            end
            @(posedge clk); #1;
        end
        access2(4'b0000, 32'h20, 32'h0);
    endtask

    task automatic test_back_to_back();
        logic [3:0]  wens[5]  = '{4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
        logic [31:0] addrs[5] = '{32'h40, 32'h44, 32'h40, 32'h44, 32'h41};
        logic [31:0] datas[5] = '{32'hCAFE_F00D, 32'h0123_4567, 32'h0, 32'h0, 32'h0};
        exp_t e;
        for (int k = 0; k < 5; k++) begin
            model(1'b1, wens[k], addrs[k], datas[k]);
            req0 = 1'b1; wen0 = wens[k]; addr0 = addrs[k]; wdata0 = datas[k];
            @(negedge clk);
            checks++;
            if (busy0 !== 1'b1 || ok0 !== 1'b0) begin
                errors++;
                $display("FAIL b2b_accept op=%0d busy=%b ok=%b required 1 0", k, busy0, ok0);
            end
            @(posedge clk); #1;
            @(negedge clk);
            e = q0.pop_front();
            checks++;
            if (ok0 !== 1'b1 || busy0 !== 1'b0) begin
                errors++;
                $display("FAIL b2b_resp op=%0d ok=%b busy=%b required 1 0", k, ok0, busy0);
            end
            checks++;
            if (rdata0 !== e.rdata || err0 !== e.err) begin
                errors++;
                $display("FAIL b2b_data op=%0d rdata=%h err=%b required rdata=%h err=%b",
                         k, rdata0, err0, e.rdata, e.err);
            end
            @(posedge clk); #1;
        end
        req0 = 1'b0;
        @(negedge clk);
        checks++;
        if (ok0 !== 1'b0 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle ok=%b busy=%b required 0 0", ok0, busy0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_full_write();
        test_byte_write();
        test_out_of_range();
        test_illegal_strobe();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
